// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, drives a 1-cycle sync ROM, fills the F/D latch; 2 edges addr->fd.
// Backpressure: stall or en=0 freezes PC/request/F-D, skid-capturing the ROM word; flush redirects and squashes.
module fetch_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_data,
  output logic [WIDTH-1:0] fd_pc,
  output logic [WIDTH-1:0] fd_insn,
  output logic [WIDTH-1:0] fd_pc_plus1,
  output logic             fd_valid
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {EMPTY, HELD} skid_t;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] req_pc;
  logic             req_valid;
  logic [WIDTH-1:0] hold_insn;
  skid_t            skid;
  logic             held;
  logic             advance;
  logic             redirect;
  logic [WIDTH-1:0] insn_in;

  assign held      = (skid == HELD);
  assign advance   = en & ~stall & ~flush;
  assign redirect  = en & flush;
  assign insn_in   = held ? hold_insn : imem_data;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!clr) begin
      pc          <= RESET_PC;
      req_pc      <= '0;
      req_valid   <= 1'b0;
      hold_insn   <= '0;
      skid        <= EMPTY;
      fd_pc       <= '0;
      fd_insn     <= '0;
      fd_pc_plus1 <= '0;
      fd_valid    <= 1'b0;
    end else if (redirect) begin
      pc        <= target;
      req_valid <= 1'b0;
      skid      <= EMPTY;
      fd_valid  <= 1'b0;
      fd_insn   <= '0;
    end else if (advance) begin
      pc          <= pc + ONE;
      req_pc      <= pc;
      req_valid   <= 1'b1;
      fd_pc       <= req_pc;
      fd_pc_plus1 <= req_pc + ONE;
      fd_insn     <= req_valid ? insn_in : '0;
      fd_valid    <= req_valid;
      skid        <= EMPTY;
    end else if (req_valid && !held) begin
      // ROM keeps re-reading pc (one ahead), so the requested word is only valid this edge
      hold_insn <= imem_data;
      skid      <= HELD;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: two instances (RESET_PC 0 and 0xFFFFFFFE) share stimulus.
module tb_fetch_stage;

  logic        clk;
  logic        clr, en, stall, flush;
  logic [31:0] target;
  logic [31:0] imem_addr [2];
  logic [31:0] imem_data [2];
  logic [31:0] fd_pc     [2];
  logic [31:0] fd_insn   [2];
  logic [31:0] fd_p1     [2];
  logic        fd_valid  [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0)) dut_a (
    .clk(clk), .clr(clr), .en(en), .stall(stall), .flush(flush), .target(target),
    .imem_addr(imem_addr[0]), .imem_data(imem_data[0]),
    .fd_pc(fd_pc[0]), .fd_insn(fd_insn[0]), .fd_pc_plus1(fd_p1[0]), .fd_valid(fd_valid[0]));

  fetch_stage #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFE)) dut_b (
    .clk(clk), .clr(clr), .en(en), .stall(stall), .flush(flush), .target(target),
    .imem_addr(imem_addr[1]), .imem_data(imem_data[1]),
    .fd_pc(fd_pc[1]), .fd_insn(fd_insn[1]), .fd_pc_plus1(fd_p1[1]), .fd_valid(fd_valid[1]));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a + 32'h1000;
  endfunction

  // Synchronous ROMs: word for the address seen at the previous edge
  always @(posedge clk) begin
    imem_data[0] <= rom(imem_addr[0]);
    imem_data[1] <= rom(imem_addr[1]);
  end

  // Reference model: one outstanding fetch address plus the visible F/D contents.
  // Instruction words are read straight from the ROM function, so no skid modelling.
  logic [31:0] m_pc [2], m_rpc [2], m_fpc [2], m_fins [2], m_fp1 [2];
  bit          m_rv [2], m_fv [2];

  function automatic logic [31:0] reset_pc(input int i);
    return (i == 0) ? 32'h0 : 32'hFFFF_FFFE;
  endfunction

  task automatic cyc(input logic c, input logic e, input logic s, input logic f,
                     input logic [31:0] t);
    clr = c; en = e; stall = s; flush = f; target = t;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!c) begin
        m_pc[i] = reset_pc(i); m_rpc[i] = 0; m_rv[i] = 0;
        m_fpc[i] = 0; m_fins[i] = 0; m_fp1[i] = 0; m_fv[i] = 0;
      end else if (e && f) begin
        m_pc[i] = t; m_rv[i] = 0; m_fv[i] = 0; m_fins[i] = 0;
      end else if (e && !s) begin
        m_fpc[i]  = m_rpc[i];
        m_fp1[i]  = m_rpc[i] + 1;
        m_fins[i] = m_rv[i] ? rom(m_rpc[i]) : 32'h0;
        m_fv[i]   = m_rv[i];
        m_rpc[i]  = m_pc[i];
        m_rv[i]   = 1;
        m_pc[i]   = m_pc[i] + 1;
      end
    end
    if (!c) chk_en = 1;
    #1;
  endtask

  // Scoreboard: every cycle, both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (imem_addr[i] !== m_pc[i] || fd_pc[i] !== m_fpc[i] || fd_insn[i] !== m_fins[i] ||
            fd_p1[i] !== m_fp1[i] || fd_valid[i] !== m_fv[i]) begin
          errors++;
          $display("FAIL model[%0d] t=%0t: got addr=%h pc=%h insn=%h p1=%h v=%b, expected addr=%h pc=%h insn=%h p1=%h v=%b",
                   i, $time, imem_addr[i], fd_pc[i], fd_insn[i], fd_p1[i], fd_valid[i],
                   m_pc[i], m_fpc[i], m_fins[i], m_fp1[i], m_fv[i]);
        end
      end
    end
  end

  task automatic test_reset();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 32'h55);
    checks++;
    if (fd_valid[0] !== 0 || fd_pc[0] !== 0 || fd_insn[0] !== 0 || fd_p1[0] !== 0 || imem_addr[0] !== 0) begin
      errors++;
      $display("FAIL reset_a: v=%b pc=%h insn=%h p1=%h addr=%h, expected all 0", fd_valid[0], fd_pc[0], fd_insn[0], fd_p1[0], imem_addr[0]);
    end
    checks++;
    if (imem_addr[1] !== 32'hFFFF_FFFE || fd_valid[1] !== 0) begin
      errors++;
      $display("FAIL reset_b: addr=%h v=%b, expected FFFFFFFE 0", imem_addr[1], fd_valid[1]);
    end
  endtask

  task automatic test_free_run();
    cyc(1, 1, 0, 0, 0);
    checks++;
    if (fd_valid[0] !== 0) begin
      errors++; $display("FAIL first_edge_valid: got %b expected 0", fd_valid[0]);
    end
    for (int k = 0; k < 5; k++) begin
      cyc(1, 1, 0, 0, 0);
      checks++;
      if (fd_valid[0] !== 1 || fd_pc[0] !== k || fd_insn[0] !== 32'h1000 + k || fd_p1[0] !== k + 1) begin
        errors++;
        $display("FAIL free_run[%0d]: v=%b pc=%h insn=%h p1=%h, expected 1 %h %h %h",
                 k, fd_valid[0], fd_pc[0], fd_insn[0], fd_p1[0], k, 32'h1000 + k, k + 1);
      end
    end
  endtask

  task automatic test_stall();
    // fd_pc is 4 on entry
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 1, 0, 0);
      checks++;
      if (fd_valid[0] !== 1 || fd_pc[0] !== 4 || fd_insn[0] !== 32'h1004) begin
        errors++;
        $display("FAIL stall_hold[%0d]: v=%b pc=%h insn=%h, expected 1 4 1004", k, fd_valid[0], fd_pc[0], fd_insn[0]);
      end
    end
    for (int k = 5; k <= 7; k++) begin
      cyc(1, 1, 0, 0, 0);
      checks++;
      if (fd_valid[0] !== 1 || fd_pc[0] !== k || fd_insn[0] !== 32'h1000 + k) begin
        errors++;
        $display("FAIL stall_resume[%0d]: v=%b pc=%h insn=%h, expected 1 %h %h", k, fd_valid[0], fd_pc[0], fd_insn[0], k, 32'h1000 + k);
      end
    end
  endtask

  task automatic test_redirect(input logic s, input logic [31:0] t, input string name);
    cyc(1, 1, s, 1, t);
    checks++;
    if (fd_valid[0] !== 0 || fd_insn[0] !== 0 || imem_addr[0] !== t) begin
      errors++;
      $display("FAIL %s_bubble0: v=%b insn=%h addr=%h, expected 0 0 %h", name, fd_valid[0], fd_insn[0], imem_addr[0], t);
    end
    cyc(1, 1, 0, 0, 0);
    checks++;
    if (fd_valid[0] !== 0 || fd_insn[0] !== 0) begin
      errors++;
      $display("FAIL %s_bubble1: v=%b insn=%h, expected 0 0", name, fd_valid[0], fd_insn[0]);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(1, 1, 0, 0, 0);
      checks++;
      if (fd_valid[0] !== 1 || fd_pc[0] !== t + k || fd_insn[0] !== rom(t + k)) begin
        errors++;
        $display("FAIL %s_target[%0d]: v=%b pc=%h insn=%h, expected 1 %h %h", name, k, fd_valid[0], fd_pc[0], fd_insn[0], t + k, rom(t + k));
      end
    end
  endtask

  task automatic test_enable();
    // fd_pc is 0x21, pc is 0x23 on entry
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, (k == 2), 32'h77);
      checks++;
      if (fd_valid[0] !== 1 || fd_pc[0] !== 32'h21 || fd_insn[0] !== 32'h1021 || imem_addr[0] !== 32'h23) begin
        errors++;
        $display("FAIL en_hold[%0d]: v=%b pc=%h insn=%h addr=%h, expected 1 21 1021 23", k, fd_valid[0], fd_pc[0], fd_insn[0], imem_addr[0]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      cyc(1, 1, 0, 0, 0);
      checks++;
      if (fd_valid[0] !== 1 || fd_pc[0] !== 32'h22 + k || fd_insn[0] !== 32'h1022 + k) begin
        errors++;
        $display("FAIL en_resume[%0d]: v=%b pc=%h insn=%h, expected 1 %h %h", k, fd_valid[0], fd_pc[0], fd_insn[0], 32'h22 + k, 32'h1022 + k);
      end
    end
  endtask

  task automatic test_wrap_reset();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFFE; exp_pc[1] = 32'hFFFF_FFFF; exp_pc[2] = 32'h0;
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 0, 0, 0);
      checks++;
      if (fd_valid[1] !== 1 || fd_pc[1] !== exp_pc[k] || fd_p1[1] !== exp_pc[k] + 1 || fd_insn[1] !== rom(exp_pc[k])) begin
        errors++;
        $display("FAIL wrap[%0d]: v=%b pc=%h p1=%h insn=%h, expected 1 %h %h %h", k, fd_valid[1], fd_pc[1], fd_p1[1], fd_insn[1],
                 exp_pc[k], exp_pc[k] + 1, rom(exp_pc[k]));
      end
    end
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    checks++;
    if (fd_valid[1] !== 0 || fd_pc[1] !== 0 || fd_insn[1] !== 0 || fd_p1[1] !== 0 ||
        dut_b.held !== 0 || imem_addr[1] !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL reset_in_stall: v=%b pc=%h insn=%h p1=%h held=%b addr=%h, expected 0 0 0 0 0 FFFFFFFE",
               fd_valid[1], fd_pc[1], fd_insn[1], fd_p1[1], dut_b.held, imem_addr[1]);
    end
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    checks++;
    if (fd_valid[1] !== 1 || fd_pc[1] !== 32'hFFFF_FFFE || fd_insn[1] !== 32'h0000_0FFE) begin
      errors++;
      $display("FAIL restart: v=%b pc=%h insn=%h, expected 1 FFFFFFFE 00000FFE", fd_valid[1], fd_pc[1], fd_insn[1]);
    end
  endtask

  task automatic test_random();
    int valid_seen = 0;
    for (int k = 0; k < 600; k++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom;
      cyc($urandom_range(0, 99) >= 2, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 25,
          $urandom_range(0, 99) < 10, t);
      if (fd_valid[0] === 1) valid_seen++;
    end
    checks++;
    if (valid_seen < 100) begin
      errors++;
      $display("FAIL random_activity: got %0d valid cycles, required at least 100", valid_seen);
    end
  endtask

  initial begin
    clr = 0; en = 0; stall = 0; flush = 0; target = 0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect(1'b0, 32'h40, "flush");
    test_redirect(1'b1, 32'h20, "stall_flush");
    test_enable();
    test_wrap_reset();
    test_random();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
